// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA sequencer.
// Holds the trigger/destination register addresses and the sequencer state encoding.
// No ports; imported by oam_dma.
package oam_dma_pkg;

   localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE,
      DONE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA sequencer: a CPU write of page P to $4014 halts the CPU and copies $PP00-$PPFF to OAMDATA.
// Ports: clk/rst (sync, active high), cpu_ce CPU-cycle strobe, CPU address/data/rw and bus read data in;
//        cpu_halt to the CPU core, dma_active bus-mux select, and registered DMA address/data/rw out.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = oam_dma_pkg::OAMDMA_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = oam_dma_pkg::OAMDATA_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_rw_i,
   input  logic [7:0]  bus_data_i,
   output logic        cpu_halt,
   output logic        dma_active,
   output logic [15:0] dma_addr_o,
   output logic [7:0]  dma_data_o,
   output logic        dma_rw_o
);

   dma_state_t  state, state_nxt;
   logic        parity;           // 0 = GET cycle, 1 = PUT cycle
   logic [7:0]  page, page_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [7:0]  cnt_inc;
   logic        halt_nxt, active_nxt, rw_nxt;
   logic [15:0] addr_nxt;
   logic [7:0]  data_nxt;

   assign cnt_inc = cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         parity     <= 1'b0;
         page       <= 8'h00;
         cnt        <= 8'h00;
         cpu_halt   <= 1'b0;
         dma_active <= 1'b0;
         dma_addr_o <= 16'h0000;
         dma_data_o <= 8'h00;
         dma_rw_o   <= 1'b1;
      end else if (cpu_ce) begin
         state      <= state_nxt;
         parity     <= ~parity;
         page       <= page_nxt;
         cnt        <= cnt_nxt;
         cpu_halt   <= halt_nxt;
         dma_active <= active_nxt;
         dma_addr_o <= addr_nxt;
         dma_data_o <= data_nxt;
         dma_rw_o   <= rw_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      page_nxt   = page;
      cnt_nxt    = cnt;
      halt_nxt   = cpu_halt;
      active_nxt = dma_active;
      addr_nxt   = dma_addr_o;
      data_nxt   = dma_data_o;
      rw_nxt     = dma_rw_o;

      case (state)
         IDLE: begin
            if (!cpu_rw_i && (cpu_addr_i == DMA_REG_ADDR)) begin
               page_nxt  = cpu_data_i;
               halt_nxt  = 1'b1;
               state_nxt = HALT;
            end
         end
         HALT: begin
            // The CPU keeps completing write cycles despite RDY; the first
            // read cycle is the one it actually stalls on.
            if (cpu_rw_i) begin
               active_nxt = 1'b1;
               rw_nxt     = 1'b1;
               addr_nxt   = {page, cnt};
               // Current cycle GET means the next is PUT: burn one to realign.
               state_nxt  = parity ? READ : ALIGN;
            end
         end
         ALIGN: begin
            state_nxt = READ;
         end
         READ: begin
            // dma_data_o doubles as the byte latch for the following write.
            data_nxt  = bus_data_i;
            rw_nxt    = 1'b0;
            addr_nxt  = OAMDATA_ADDR;
            state_nxt = WRITE;
         end
         WRITE: begin
            cnt_nxt = cnt_inc;
            rw_nxt  = 1'b1;
            if (cnt == 8'hFF) begin
               // Termination is folded into this edge so the CPU resumes
               // on the very next cycle.
               halt_nxt   = 1'b0;
               active_nxt = 1'b0;
               cnt_nxt    = 8'h00;
               state_nxt  = IDLE;
            end else begin
               addr_nxt  = {page, cnt_inc};
               state_nxt = READ;
            end
         end
         DONE: begin
            halt_nxt   = 1'b0;
            active_nxt = 1'b0;
            rw_nxt     = 1'b1;
            cnt_nxt    = 8'h00;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: models CPU cycles, system memory and the OAM/OAMADDR side of the PPU.
// Expected DMA bus cycles are queued when the halt cycle is driven and popped on every DMA-owned cycle.
// Ports: none (top-level bench).
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_data_i;
   logic        cpu_rw_i;
   logic [7:0]  bus_data_i;
   logic        cpu_halt;
   logic        dma_active;
   logic [15:0] dma_addr_o;
   logic [7:0]  dma_data_o;
   logic        dma_rw_o;

   oam_dma dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_ce     (cpu_ce),
      .cpu_addr_i (cpu_addr_i),
      .cpu_data_i (cpu_data_i),
      .cpu_rw_i   (cpu_rw_i),
      .bus_data_i (bus_data_i),
      .cpu_halt   (cpu_halt),
      .dma_active (dma_active),
      .dma_addr_o (dma_addr_o),
      .dma_data_o (dma_data_o),
      .dma_rw_o   (dma_rw_o)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:65535];
   logic [7:0]  oam [0:255];
   logic [7:0]  oamaddr;
   logic [24:0] exp_q [$];
   int          vectors = 0;
   int          errors  = 0;
   int          cyc     = 0;   // CPU cycles completed since reset; bit 0 is the bench's own parity
   int          halt_cnt;
   int          wr_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One CPU cycle: optional idle clks with cpu_ce low, then the strobe clk.
   // Outputs are sampled on the falling edge before the strobe.
   task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input int max_gap);
      int          gap;
      logic [24:0] got;
      logic [24:0] exp;
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
         @(negedge clk);
         cpu_ce = 1'b0;
      end
      @(negedge clk);
      cpu_addr_i = a;
      cpu_data_i = d;
      cpu_rw_i   = rw;
      bus_data_i = (dma_active && dma_rw_o) ? mem[dma_addr_o] : 8'($urandom);
      if (cpu_halt) halt_cnt++;
      if (dma_active) begin
         got = {dma_addr_o, dma_rw_o, (dma_rw_o ? 8'h00 : dma_data_o)};
         if (exp_q.size() == 0) begin
            chk("sb_underrun", 32'(exp_q.size()), 32'd1);
         end else begin
            exp = exp_q.pop_front();
            chk("bus_cycle", 32'(got), 32'(exp));
         end
         if (!dma_rw_o && dma_addr_o == 16'h2004) begin
            oam[oamaddr] = dma_data_o;
            oamaddr      = oamaddr + 8'd1;
            wr_cnt++;
         end
      end
      cpu_ce = 1'b1;
      @(posedge clk);
      #1;
      cpu_ce = 1'b0;
      cyc++;
   endtask

   // Trigger a transfer from page pg, optionally with extra CPU write cycles
   // before the halt takes effect. exp_total of 0 derives the halt length from
   // the bench parity. A nonzero stop_after returns once that many bytes landed.
   task automatic run_dma(input logic [7:0] pg, input int n_extra, input int max_gap,
                          input int exp_total, input int stop_after);
      int         tot;
      int         n;
      logic       align;
      logic [15:0] src;
      halt_cnt = 0;
      wr_cnt   = 0;
      cpu_cycle(16'h4014, pg, 1'b0, max_gap);
      chk("halt_set", 32'(cpu_halt), 32'd1);
      for (int k = 0; k < n_extra; k++) begin
         chk("halt_hold_inactive", 32'(dma_active), 32'd0);
         cpu_cycle(16'h0300 + 16'(k), 8'h5A, 1'b0, max_gap);
      end
      chk("halt_cycle_state", 32'({cpu_halt, dma_active}), 32'h2);
      // The halt cycle is about to run; if it is GET the DMA needs an ALIGN cycle.
      align = ((cyc % 2) == 0);
      tot   = (exp_total != 0) ? exp_total : (513 + n_extra + int'(align));
      if (align) exp_q.push_back({pg, 8'h00, 1'b1, 8'h00});
      for (int i = 0; i < 256; i++) begin
         src = {pg, 8'(i)};
         exp_q.push_back({src, 1'b1, 8'h00});
         exp_q.push_back({16'h2004, 1'b0, mem[src]});
      end
      n = 0;
      while (cpu_halt && n < 1200) begin
         cpu_cycle(16'h8000, 8'h00, 1'b1, max_gap);
         n++;
         if (stop_after != 0 && wr_cnt == stop_after) return;
      end
      chk("halt_released", 32'(cpu_halt), 32'd0);
      chk("active_released", 32'(dma_active), 32'd0);
      chk("halt_cycles", 32'(halt_cnt), 32'(tot));
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("oam_writes", 32'(wr_cnt), 32'd256);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", vectors);
      $fatal(1);
   end

   initial begin
      logic [15:0] aa;
      for (int a = 0; a < 65536; a++) begin
         aa = 16'(a);
         mem[a] = (aa[15:8] == 8'h07) ? (aa[7:0] ^ 8'hA5) : ((aa[7:0] * 8'd7) ^ aa[15:8]);
      end
      for (int i = 0; i < 256; i++) oam[i] = 8'h00;
      oamaddr    = 8'h00;
      rst        = 1'b1;
      cpu_ce     = 1'b0;
      cpu_addr_i = 16'h0000;
      cpu_data_i = 8'h00;
      cpu_rw_i   = 1'b1;
      bus_data_i = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_halt", 32'(cpu_halt), 32'd0);
      chk("rst_active", 32'(dma_active), 32'd0);
      chk("rst_addr", 32'(dma_addr_o), 32'd0);
      chk("rst_data", 32'(dma_data_o), 32'd0);
      chk("rst_rw", 32'(dma_rw_o), 32'd1);
      cyc = 0;

      // Trigger on cycle 0 (GET): halt cycle is PUT, READ starts on GET.
      run_dma(8'h02, 0, 0, 513, 0);
      // One idle cycle shifts the trigger to PUT, forcing an ALIGN cycle.
      cpu_cycle(16'h8000, 8'h00, 1'b1, 0);
      run_dma(8'h02, 0, 0, 514, 0);
      // Two further CPU writes keep the sequencer in HALT.
      run_dma(8'h02, 2, 0, 515, 0);

      // Reset in the middle of the transfer.
      run_dma(8'h03, 0, 0, 0, 100);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_halt", 32'(cpu_halt), 32'd0);
      chk("midrst_active", 32'(dma_active), 32'd0);
      chk("midrst_rw", 32'(dma_rw_o), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      exp_q.delete();
      wr_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         chk("postrst_idle", 32'(dma_active), 32'd0);
         cpu_cycle(16'h8000, 8'h00, 1'b1, 0);
      end
      chk("postrst_no_write", 32'(wr_cnt), 32'd0);

      // Restart after reset with OAMADDR offset; verify OAM contents.
      oamaddr = 8'h10;
      run_dma(8'h07, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) begin
         chk("oam_fill", 32'(oam[8'(i + 16)]), 32'(8'(i) ^ 8'hA5));
      end

      // Same parity as the first run, with cpu_ce throttled.
      run_dma(8'h02, 0, 7, 513, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
